// File: rtl/crosswalk_arbiter_pkg.sv
// Shared types and default phase lengths for the crosswalk arbiter.
package crosswalk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    CLEAR,
    ALLRED
  } state_t;

  typedef logic dir_t;

  localparam dir_t DIR_X = 1'b0;
  localparam dir_t DIR_Y = 1'b1;

  localparam int unsigned WALK_CYCLES_DEF   = 8;
  localparam int unsigned CLEAR_CYCLES_DEF  = 4;
  localparam int unsigned ALLRED_CYCLES_DEF = 2;
  localparam int unsigned CNT_W_DEF         = 8;

endpackage

// File: rtl/crosswalk_arbiter_if.sv
// Button requests in, lamp/status lines out.
interface crosswalk_arbiter_if;

  logic req_x;
  logic req_y;
  logic walk_x;
  logic walk_y;
  logic flash_x;
  logic flash_y;
  logic busy;
  logic done_x;
  logic done_y;

  modport master (
    output req_x, req_y,
    input  walk_x, walk_y, flash_x, flash_y, busy, done_x, done_y
  );

  modport slave (
    input  req_x, req_y,
    output walk_x, walk_y, flash_x, flash_y, busy, done_x, done_y
  );

endinterface

// File: rtl/crosswalk_arbiter_timer.sv
// Down-counting phase timer: load strobe wins, otherwise counts down to 0 and holds.
module walk_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Counter register: load, or decrement while enabled and non-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/crosswalk_arbiter.sv
// Round-robin pedestrian crossing sequencer for two directions (X, Y).
module crosswalk_arbiter
  import crosswalk_pkg::*;
#(
  parameter int unsigned WALK_CYCLES   = WALK_CYCLES_DEF,
  parameter int unsigned CLEAR_CYCLES  = CLEAR_CYCLES_DEF,
  parameter int unsigned ALLRED_CYCLES = ALLRED_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst,
  crosswalk_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYCLES - 1);

  state_t state, state_n;
  dir_t   cur_dir, cur_dir_n;
  dir_t   last_dir, last_dir_n;
  dir_t   grant;
  logic   pend_x, pend_x_n;
  logic   pend_y, pend_y_n;
  logic   flash_tog, flash_tog_n;
  logic   done_x, done_x_n;
  logic   done_y, done_y_n;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expired;

  walk_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (state != IDLE),
    .load_val(tmr_val),
    .expired (tmr_expired)
  );

  // State, direction, pending-request and done-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_dir   <= DIR_X;
      last_dir  <= DIR_Y;
      pend_x    <= 1'b0;
      pend_y    <= 1'b0;
      flash_tog <= 1'b0;
      done_x    <= 1'b0;
      done_y    <= 1'b0;
    end else begin
      state     <= state_n;
      cur_dir   <= cur_dir_n;
      last_dir  <= last_dir_n;
      pend_x    <= pend_x_n;
      pend_y    <= pend_y_n;
      flash_tog <= flash_tog_n;
      done_x    <= done_x_n;
      done_y    <= done_y_n;
    end
  end

  // Next-state logic: request latching, round-robin grant and phase sequencing.
  always_comb begin
    state_n     = state;
    cur_dir_n   = cur_dir;
    last_dir_n  = last_dir;
    flash_tog_n = flash_tog;
    done_x_n    = 1'b0;
    done_y_n    = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    grant       = DIR_X;
    // A direction's own button is ignored only while it is walking.
    pend_x_n = pend_x | (bus.req_x & ~((state == WALK) && (cur_dir == DIR_X)));
    pend_y_n = pend_y | (bus.req_y & ~((state == WALK) && (cur_dir == DIR_Y)));

    case (state)
      IDLE: begin
        if (pend_x || pend_y) begin
          if (pend_x && pend_y) begin
            grant = ~last_dir;
          end else begin
            grant = pend_x ? DIR_X : DIR_Y;
          end
          state_n    = WALK;
          cur_dir_n  = grant;
          last_dir_n = grant;
          tmr_load   = 1'b1;
          tmr_val    = WALK_LOAD;
          // Clearing on the grant edge overrides a request sampled on that same edge.
          if (grant == DIR_X) begin
            pend_x_n = 1'b0;
          end else begin
            pend_y_n = 1'b0;
          end
        end
      end
      WALK: begin
        if (tmr_expired) begin
          state_n     = CLEAR;
          tmr_load    = 1'b1;
          tmr_val     = CLEAR_LOAD;
          flash_tog_n = 1'b1;
        end
      end
      CLEAR: begin
        flash_tog_n = ~flash_tog;
        if (tmr_expired) begin
          state_n  = ALLRED;
          tmr_load = 1'b1;
          tmr_val  = ALLRED_LOAD;
        end
      end
      ALLRED: begin
        if (tmr_expired) begin
          state_n  = IDLE;
          done_x_n = (cur_dir == DIR_X);
          done_y_n = (cur_dir == DIR_Y);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.walk_x  = (state == WALK)  && (cur_dir == DIR_X);
  assign bus.walk_y  = (state == WALK)  && (cur_dir == DIR_Y);
  assign bus.flash_x = (state == CLEAR) && (cur_dir == DIR_X) && flash_tog;
  assign bus.flash_y = (state == CLEAR) && (cur_dir == DIR_Y) && flash_tog;
  assign bus.busy    = (state != IDLE);
  assign bus.done_x  = done_x;
  assign bus.done_y  = done_y;

endmodule

// File: doc/crosswalk_arbiter.md
Name: crosswalk_arbiter

Overview:
Sequences the pedestrian walk signals for two crossing directions, X and Y, and shares the single crossing resource between their request buttons.
- Latches button requests and grants one direction at a time, round-robin.
- Times the WALK, flashing CLEAR and ALL-RED phases.
- Drives the walk_x/walk_y lines, which downstream walk-signal registers sample each clock.

Parameters:
WALK_CYCLES, 8, cycles walk lamp is on per grant (>=1)
CLEAR_CYCLES, 4, cycles of flashing clearance after walk (>=1)
ALLRED_CYCLES, 2, cycles both directions dark before next grant (>=1)
CNT_W, 8, phase counter width; must hold max(parameters)-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req_x  input  1  X button, level or pulse, sampled each rising edge
req_y  input  1  Y button, level or pulse, sampled each rising edge
walk_x  output  1  X walk lamp
walk_y  output  1  Y walk lamp
flash_x  output  1  X clearance flash
flash_y  output  1  Y clearance flash
busy  output  1  high in any state other than IDLE
done_x  output  1  one-cycle pulse: X service finished
done_y  output  1  one-cycle pulse: Y service finished

Behaviour:
Reset and clocking:
- One clock (clk); reset is asynchronous and active-high (rst).
- On rst: state=IDLE, counter=0, pend_x=pend_y=0, last_dir=Y, all outputs 0.
- Reset asserted mid-phase kills the cycle immediately; no done pulse is produced.

Request latching:
- req_d high at an edge sets pend_d (sticky).
- pend_d clears on the edge that enters WALK for d.
- req_d is ignored while d is in WALK.
- req_d is latched normally during d's CLEAR/ALLRED, giving a new service later.

State machine (IDLE, WALK, CLEAR, ALLRED; cur_dir register):
- IDLE:
  - If exactly one pend is set, go to WALK for that direction.
  - If both are set, grant the direction != last_dir.
  - On grant: cur_dir<=granted, last_dir<=granted, counter<=WALK_CYCLES-1.
  - With no pend, stay in IDLE.
- WALK: walk_<cur> = 1. Counter decrements each edge; at 0, go to CLEAR with counter<=CLEAR_CYCLES-1.
- CLEAR: flash_<cur> = 1 on the 1st, 3rd, 5th... CLEAR cycle and 0 otherwise (derived from a toggle reset to 1 on entry). At counter 0, go to ALLRED with counter<=ALLRED_CYCLES-1.
- ALLRED: all lamps 0. At counter 0, go to IDLE.
- done_<cur> is a one-cycle pulse in the first IDLE cycle after ALLRED.
- Outputs are registered/Moore: walk_x and walk_y are never simultaneously 1, and walk and flash are never simultaneously 1.

Latency:
- req sampled at edge k → pend set at edge k → WALK entered at edge k+1.
- A full service is WALK+CLEAR+ALLRED cycles, then at least 1 IDLE cycle before the next grant.

Simultaneous events:
- req_x and req_y at the same edge from reset: X is served first (last_dir resets to Y).
- Continuous requests on both directions alternate strictly X, Y, X, ...
- Counter width: the counter never wraps; it is always loaded before use.

Decomposition:
- Package crosswalk_pkg holds:
  - state enum {IDLE, WALK, CLEAR, ALLRED};
  - DIR_X=1'b0, DIR_Y=1'b1;
  - the default phase-length constants.
- Sub-module walk_phase_timer (CNT_W): load value/strobe, decrement, expire flag. It is instantiated once in crosswalk_arbiter.

Test Plan:
1. Reset, then a req_x one-cycle pulse at edge 0. Required: walk_x=1 after edges 1..8; flash_x=1 after edges 9 and 11, 0 after edges 10 and 12; all lamps 0 after edges 13..14; done_x=1 only after edge 15; busy=0 after edge 15.
2. req_x and req_y together at edge 0. Required: X served first per scenario 1; walk_y rises after edge 16; done_y after edge 31; walk_x and walk_y never both 1.
3. req_x held high continuously. Required: no re-grant from the held request during WALK. The request is latched in CLEAR, and the next walk_x starts after edge 16.
4. Both requests held high for 60 cycles. Required: grants alternate X,Y,X,Y with 16-cycle spacing.
5. rst asserted asynchronously mid-WALK (between edges 4 and 5). Required: walk_x drops immediately, pending requests cleared, no done pulse. After release, a fresh req_y is granted with the scenario-1 timing.
6. Parameters WALK=1, CLEAR=1, ALLRED=1 with req_y at edge 0. Required: walk_y after edge 1 only, flash_y after edge 2 only, all lamps dark after edge 3, done_y after edge 4.
